cv32e40p_x_disp_mo: RTL
=======================

Name: cv32e40p_x_disp_mo

Overview:
- Multi-outstanding successor of the single-outstanding X-interface dispatcher in the cv32e40p ID stage.
- Offloads instructions to the coprocessor and tags each one with an instruction ID.
- Tracks up to MAX_OUTSTANDING in-flight results with a per-register pending-count scoreboard, so several writes to the same rd may be in flight.
- Result-side rd comes from an ID-indexed in-flight table; the coprocessor does not supply it.

Parameters:
X_ID_WIDTH, 4, width of the instruction/result ID; in-flight table depth is 2**X_ID_WIDTH.
X_NUM_RS, 3, number of source-register operands checked and reported.
MAX_OUTSTANDING, 4, maximum in-flight writeback instructions; legal range 1..2**X_ID_WIDTH.
SB_CNT_WIDTH, 2, width of each per-register pending counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
x_illegal_insn_dec_i  in  1  core decoder flags the instruction as a candidate for offload
x_branch_or_jump_i  in  1  branch/jump unresolved; offload is blocked
id_ready_i  in  1  ID stage advances
x_rs_addr_i  in  X_NUM_RS*5  source register addresses
x_regs_used_i  in  X_NUM_RS  source-used flags for core-local instructions
x_waddr_id_i  in  5  rd of the instruction in ID
x_writeback_i  in  1  offloaded instruction writes rd
x_waddr_ex_i, x_waddr_wb_i  in  5 each  pending core-pipeline writes
x_we_ex_i, x_we_wb_i  in  1 each  write enables for the above
x_valid_o  out  1  offload request
x_ready_i  in  1  coprocessor ready
x_accept_i  in  1  coprocessor accepts the instruction
x_id_o  out  X_ID_WIDTH  ID of the current request
x_rs_valid_o  out  X_NUM_RS  operand hazard-free
x_rd_clean_o  out  1  no pending write to rd
x_stall_o  out  1  stall the ID stage
x_illegal_insn_o  out  1  rejected offload; raise illegal instruction
x_rvalid_i  in  1  result valid
x_rid_i  in  X_ID_WIDTH  result ID
x_rready_o  out  1  result ready; constant 1
x_rwaddr_o  out  5  rd looked up for x_rid_i (combinational)
x_rwe_o  out  1  register-file write enable for the result
x_rerr_o  out  1  result carried an unknown or invalid ID (one-cycle pulse)
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight writeback count

Behaviour:
- Reset state: all sb_cnt = 0; table valid bits = 0; id_q = 0; outstanding = 0; offloaded_q = 0.
- Reset output values: x_valid_o, x_illegal_insn_o, x_rwe_o, x_rerr_o, x_stall_o = 0 (given x_illegal_insn_dec_i = 0); x_rready_o = 1.
- Reset mid-operation discards every in-flight entry; late results then raise x_rerr_o.
- blk (blocked) = x_writeback_i & x_waddr_id_i != 0 & (outstanding == MAX_OUTSTANDING | sb_cnt[x_waddr_id_i] == all-ones | table[id_q].valid).
- cand (candidate) = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~offloaded_q.
- x_valid_o = cand & ~blk. x_id_o = id_q.
- Handshake hs = x_valid_o & x_ready_i. Accept acc = hs & x_accept_i. Rejection: x_illegal_insn_o = hs & ~x_accept_i, same cycle.
- offloaded_q: cleared by id_ready_i (priority); otherwise set by hs. Prevents re-offload while ID is stalled.
- On acc:
  - id_q increments, wrapping modulo 2**X_ID_WIDTH.
  - If x_writeback_i and rd != 0: table[id_q] = {1, rd}; sb_cnt[rd]++; outstanding++.
  - rd == 0, or no writeback: no tracking.
- Result handling (x_rready_o = 1):
  - If x_rvalid_i & table[x_rid_i].valid: x_rwe_o = 1 and x_rwaddr_o = table rd, same cycle. Entry cleared; sb_cnt[rd]--; outstanding--.
  - If x_rvalid_i with an invalid entry: x_rerr_o = 1 and x_rwe_o = 0; no state change.
- Simultaneous acc and retire to the same rd: sb_cnt unchanged. Same for outstanding: net 0.
- Operand and rd checks:
  - x_rs_valid_o[i] = (sb_cnt[rs_i] == 0) & no EX/WB hazard on rs_i.
  - Address 0 is always valid.
  - x_rd_clean_o uses the same test on x_waddr_id_i.
- dep = OR over i of (x_regs_used_i[i] & sb_cnt[rs_i] != 0).
- x_stall_o = (x_valid_o & ~x_ready_i) | dep | (cand & blk).
- No memory-transaction support; memory requests are handled by a separate block.

Optional Feature:
CV32E40P_X_DISP_WAW_STALL_EN
- Defined: blk additionally includes sb_cnt[x_waddr_id_i] != 0, so at most one pending write per register is allowed. Counters then never exceed 1.
- Undefined: multiple outstanding writes to the same rd are allowed up to counter saturation.

Test Plan:
- Offload 4 writeback instructions to rd = 5, 6, 7, 8 with ready = accept = 1, MAX_OUTSTANDING = 4 -> x_id_o = 0, 1, 2, 3; outstanding_o = 4; 5th candidate gives x_valid_o = 0 and x_stall_o = 1.
- Return results with rid = 2 then rid = 0 -> x_rwaddr_o = 7 then 5, x_rwe_o = 1 each; outstanding_o = 2; sb_cnt[7] and sb_cnt[5] = 0.
- x_rvalid_i with rid = 9 (no entry) -> x_rerr_o = 1 for one cycle; x_rwe_o = 0; outstanding_o unchanged.
- ready = 1, accept = 0 -> x_illegal_insn_o = 1 same cycle; id_q not incremented; no scoreboard change.
- Two offloads to rd = 3 (macro undefined) -> sb_cnt[3] = 2; core instruction using rs1 = 3 stalls until both results retire. Macro defined -> second offload stalls instead.
- Offload rd = 3 while the result for rd = 3 retires in the same cycle -> sb_cnt[3] stays 1, outstanding_o unchanged.

Source files
------------

// File: rtl/cv32e40p_x_disp_mo.sv
//------------------------------------------------------------------------------
// Module   : cv32e40p_x_disp_mo
// Brief    : Multi-outstanding X-interface dispatcher for the cv32e40p ID
//            stage. Tags offloaded instructions with an ID, keeps an
//            ID-indexed in-flight table of destination registers and a
//            per-register pending-write counter scoreboard.
// Options  : CV32E40P_X_DISP_WAW_STALL_EN - allow at most one pending write
//            per destination register (stall on WAW instead of counting).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cv32e40p_x_disp_mo #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned X_NUM_RS        = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SB_CNT_WIDTH    = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   x_illegal_insn_dec_i,
  input  logic                                   x_branch_or_jump_i,
  input  logic                                   id_ready_i,
  input  logic [X_NUM_RS*5-1:0]                  x_rs_addr_i,
  input  logic [X_NUM_RS-1:0]                    x_regs_used_i,
  input  logic [4:0]                             x_waddr_id_i,
  input  logic                                   x_writeback_i,
  input  logic [4:0]                             x_waddr_ex_i,
  input  logic [4:0]                             x_waddr_wb_i,
  input  logic                                   x_we_ex_i,
  input  logic                                   x_we_wb_i,
  output logic                                   x_valid_o,
  input  logic                                   x_ready_i,
  input  logic                                   x_accept_i,
  output logic [X_ID_WIDTH-1:0]                  x_id_o,
  output logic [X_NUM_RS-1:0]                    x_rs_valid_o,
  output logic                                   x_rd_clean_o,
  output logic                                   x_stall_o,
  output logic                                   x_illegal_insn_o,
  input  logic                                   x_rvalid_i,
  input  logic [X_ID_WIDTH-1:0]                  x_rid_i,
  output logic                                   x_rready_o,
  output logic [4:0]                             x_rwaddr_o,
  output logic                                   x_rwe_o,
  output logic                                   x_rerr_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned                 c_DEPTH    = 2**X_ID_WIDTH;
  localparam int unsigned                 c_OUT_W    = $clog2(MAX_OUTSTANDING+1);
  localparam logic [c_OUT_W-1:0]          c_MAX_OUT  = c_OUT_W'(MAX_OUTSTANDING);
  localparam logic [SB_CNT_WIDTH-1:0]     c_CNT_FULL = '1;

  // Architectural state
  logic [SB_CNT_WIDTH-1:0] r_sb_cnt [32];
  logic [c_DEPTH-1:0]      r_tab_valid;
  logic [4:0]              r_tab_rd [c_DEPTH];
  logic [X_ID_WIDTH-1:0]   r_id;
  logic [c_OUT_W-1:0]      r_outstanding;
  logic                    r_offloaded;

  // Dispatch-side decode
  logic                    w_track_rd;
  logic [SB_CNT_WIDTH-1:0] w_rd_cnt;
  logic                    w_waw;
  logic                    w_blk;
  logic                    w_cand;
  logic                    w_hs;
  logic                    w_acc;
  logic                    w_acc_track;
  logic                    w_ret_hit;
  logic [X_NUM_RS-1:0]     w_dep_vec;

  assign w_track_rd = x_writeback_i & (x_waddr_id_i != 5'd0);
  assign w_rd_cnt   = r_sb_cnt[x_waddr_id_i];

`ifdef CV32E40P_X_DISP_WAW_STALL_EN
  assign w_waw = (w_rd_cnt != '0);
`else
  assign w_waw = 1'b0;
`endif

  // A tracked offload needs a free outstanding slot, counter headroom and a
  // free table entry at the ID it would be tagged with.
  assign w_blk = w_track_rd & ((r_outstanding == c_MAX_OUT) | (w_rd_cnt == c_CNT_FULL) |
                               r_tab_valid[r_id] | w_waw);

  assign w_cand           = x_illegal_insn_dec_i & ~x_branch_or_jump_i & ~r_offloaded;
  assign x_valid_o        = w_cand & ~w_blk;
  assign x_id_o           = r_id;
  assign w_hs             = x_valid_o & x_ready_i;
  assign w_acc            = w_hs & x_accept_i;
  assign w_acc_track      = w_acc & w_track_rd;
  assign x_illegal_insn_o = w_hs & ~x_accept_i;

  // Result side: rd comes from the in-flight table, not from the coprocessor
  assign w_ret_hit  = r_tab_valid[x_rid_i];
  assign x_rready_o = 1'b1;
  assign x_rwaddr_o = r_tab_rd[x_rid_i];
  assign x_rwe_o    = x_rvalid_i & w_ret_hit;
  assign x_rerr_o   = x_rvalid_i & ~w_ret_hit;

  // Per-operand hazard checks; register 0 is never pending
  generate
    for (genvar gi = 0; gi < X_NUM_RS; gi++) begin : g_rs
      logic [4:0] w_addr;
      logic       w_busy;
      assign w_addr = x_rs_addr_i[gi*5 +: 5];
      assign w_busy = (r_sb_cnt[w_addr] != '0);
      assign x_rs_valid_o[gi] = (w_addr == 5'd0) |
                                (~w_busy & ~(x_we_ex_i & (x_waddr_ex_i == w_addr)) &
                                 ~(x_we_wb_i & (x_waddr_wb_i == w_addr)));
      assign w_dep_vec[gi] = x_regs_used_i[gi] & w_busy;
    end
  endgenerate

  assign x_rd_clean_o = (x_waddr_id_i == 5'd0) |
                        ((w_rd_cnt == '0) & ~(x_we_ex_i & (x_waddr_ex_i == x_waddr_id_i)) &
                         ~(x_we_wb_i & (x_waddr_wb_i == x_waddr_id_i)));

  assign x_stall_o     = (x_valid_o & ~x_ready_i) | (|w_dep_vec) | (w_cand & w_blk);
  assign outstanding_o = r_outstanding;

  // Pending-write counters: increment on tracked accept, decrement on retire
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) r_sb_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        case ({w_acc_track & (x_waddr_id_i == 5'(r)), x_rwe_o & (x_rwaddr_o == 5'(r))})
          2'b10:   r_sb_cnt[r] <= r_sb_cnt[r] + 1'b1;
          2'b01:   r_sb_cnt[r] <= r_sb_cnt[r] - 1'b1;
          default: r_sb_cnt[r] <= r_sb_cnt[r];
        endcase
      end
    end
  end

  // Table valid bits: retire clears, tracked accept sets (never the same index)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tab_valid <= '0;
    end else begin
      if (x_rwe_o)     r_tab_valid[x_rid_i] <= 1'b0;
      if (w_acc_track) r_tab_valid[r_id]    <= 1'b1;
    end
  end

  // Table rd payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk_i) begin
    if (w_acc_track) r_tab_rd[r_id] <= x_waddr_id_i;
  end

  // Instruction ID, in-flight count and the offloaded-once flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id          <= '0;
      r_outstanding <= '0;
      r_offloaded   <= 1'b0;
    end else begin
      if (w_acc) r_id <= r_id + 1'b1;
      case ({w_acc_track, x_rwe_o})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (id_ready_i)  r_offloaded <= 1'b0;
      else if (w_hs)   r_offloaded <= 1'b1;
    end
  end

endmodule

`default_nettype wire
